// File: rtl/tone_detector.sv
// Square-wave pitch tracker: measures input half-periods and maps a stable pair to a 7-bit note ID.
// Result registered k+3 cycles after the launching edge (k = octave shifts, <= 10); no backpressure.
module tone_detector #(
   parameter int unsigned TIMEOUT = 1048575,
   parameter int unsigned TOL     = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       lineIn,
   output logic [6:0] noteID,
   output logic       noteValid,
   output logic       noteChanged
);

   localparam logic [19:0] HP_MAX    = '1;
   localparam logic [19:0] TIMEOUT_C = 20'(TIMEOUT);
   localparam logic [19:0] TOL_C     = 20'(TOL);

   typedef enum logic [1:0] {IDLE, NORM, CLASS, UPD} state_t;

   state_t      state, state_n;
   logic        sync1, sync2, sync3;
   logic        line_edge;
   logic [19:0] hp, prev_h, diff;
   logic        timeout, launch;
   logic [19:0] m;
   logic [3:0]  k;
   logic [3:0]  note;
   logic [7:0]  id_calc, id_r;
   logic        norm_shift, match;

   assign line_edge  = sync2 ^ sync3;
   assign timeout    = (hp >= TIMEOUT_C);
   assign diff       = (hp > prev_h) ? (hp - prev_h) : (prev_h - hp);
   assign launch     = line_edge && (prev_h != '0) && (diff <= TOL_C) && (state == IDLE);
   assign norm_shift = (m >= 20'd528) && (k < 4'd10);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         sync3  <= 1'b0;
         hp     <= '0;
         prev_h <= '0;
      end else begin
         sync1 <= lineIn;
         sync2 <= sync1;
         sync3 <= sync2;
         // An edge coinciding with a timeout still seeds prev_h from the captured count.
         if (line_edge) begin
            hp     <= 20'd1;
            prev_h <= hp;
         end else begin
            if (hp != HP_MAX) hp <= hp + 20'd1;
            if (timeout) prev_h <= '0;
         end
      end
   end

   always_comb begin
      note = 4'd11;
      if      (m >= 20'd498) note = 4'd0;
      else if (m >= 20'd470) note = 4'd1;
      else if (m >= 20'd444) note = 4'd2;
      else if (m >= 20'd419) note = 4'd3;
      else if (m >= 20'd395) note = 4'd4;
      else if (m >= 20'd373) note = 4'd5;
      else if (m >= 20'd352) note = 4'd6;
      else if (m >= 20'd333) note = 4'd7;
      else if (m >= 20'd314) note = 4'd8;
      else if (m >= 20'd296) note = 4'd9;
      else if (m >= 20'd279) note = 4'd10;
      id_calc = 8'(8'd12 * (8'd10 - {4'd0, k})) + {4'd0, note};
      match   = (m >= 20'd264) && (m <= 20'd527) && (id_calc <= 8'd127);
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:  if (launch) state_n = NORM;
         NORM:  if (!norm_shift) state_n = CLASS;
         CLASS: state_n = match ? UPD : IDLE;
         UPD:   state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         m     <= '0;
         k     <= '0;
         id_r  <= '0;
      end else begin
         state <= state_n;
         if (launch) begin
            m <= hp;
            k <= '0;
         end else if (state == NORM && norm_shift) begin
            m <= m >> 1;
            k <= k + 4'd1;
         end
         if (state == CLASS) id_r <= id_calc;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         noteID      <= '0;
         noteValid   <= 1'b0;
         noteChanged <= 1'b0;
      end else begin
         noteChanged <= 1'b0;
         if (timeout) begin
            noteID      <= '0;
            noteValid   <= 1'b0;
            noteChanged <= (noteID != '0);
         end else if (state == UPD) begin
            noteID      <= id_r[6:0];
            noteValid   <= (id_r != '0);
            noteChanged <= (id_r[6:0] != noteID);
         end
      end
   end

endmodule

// File: tb/tb_tone_detector.sv
// Directed bench: expected note IDs are queued per stimulus phase and matched against each noteChanged pulse.
module tb_tone_detector;

   logic       clk = 1'b0;
   logic       reset;
   logic       lineIn;
   logic [6:0] noteID;
   logic       noteValid;
   logic       noteChanged;

   int passed = 0;
   int total  = 0;
   int since  = 0;
   int exp_q[$];

   tone_detector #(.TIMEOUT(5000), .TOL(3)) dut (
      .clk(clk),
      .reset(reset),
      .lineIn(lineIn),
      .noteID(noteID),
      .noteValid(noteValid),
      .noteChanged(noteChanged)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int expv);
      total++;
      if (got == expv) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, got, expv);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
      since += n;
   endtask

   // Toggle lineIn so that exactly h cycles separate it from the previous toggle.
   task automatic tog(input int h);
      repeat (h - since) @(negedge clk);
      lineIn = ~lineIn;
      since  = 0;
   endtask

   always @(negedge clk) begin
      if (reset && noteChanged) begin
         if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_pulse: got noteID %0d expected no pulse", noteID);
         end else begin
            int e;
            e = exp_q.pop_front();
            chk("pulse_noteID", int'(noteID), e);
            chk("pulse_noteValid", int'(noteValid), (e != 0) ? 1 : 0);
         end
      end
   end

   initial begin
      reset  = 1'b0;
      lineIn = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_noteID", int'(noteID), 0);
      chk("reset_noteValid", int'(noteValid), 0);
      chk("reset_noteChanged", int'(noteChanged), 0);
      reset = 1'b1;

      // lock: seed, first measurement, matching second measurement -> 608 = 304<<1 -> id 117
      tog(150);
      tog(608);
      exp_q.push_back(117);
      tog(608);
      tog(608);
      tog(608);
      wait_cyc(25);
      chk("lock_noteID", int'(noteID), 117);
      chk("lock_noteValid", int'(noteValid), 1);

      // jitter within TOL keeps 117 silently; a 14-cycle jump does not launch
      tog(611);
      tog(608);
      tog(611);
      tog(608);
      tog(622);
      tog(608);
      wait_cyc(25);
      chk("jitter_noteID", int'(noteID), 117);

      // tone change: 862 = 431<<1 -> id 111 after two edges
      tog(862);
      exp_q.push_back(111);
      tog(862);
      wait_cyc(25);
      chk("change_noteID", int'(noteID), 111);

      // 342 -> octave 10 note 7 -> 127
      tog(342);
      exp_q.push_back(127);
      tog(342);
      wait_cyc(25);
      chk("max_id_noteID", int'(noteID), 127);

      // 323 -> 128, 304 -> 129, 100 -> too high: none update
      tog(323);
      tog(323);
      tog(304);
      tog(304);
      tog(100);
      tog(100);
      tog(100);
      wait_cyc(25);
      chk("nomatch_noteID", int'(noteID), 127);
      chk("nomatch_noteValid", int'(noteValid), 1);

      // 3864 = 483<<3 -> octave 7 note 1 -> 85
      tog(3864);
      exp_q.push_back(85);
      tog(3864);
      wait_cyc(25);
      chk("octave_noteID", int'(noteID), 85);

      // timeout after 5000 static cycles
      exp_q.push_back(0);
      wait_cyc(8000);
      chk("timeout_noteID", int'(noteID), 0);
      chk("timeout_noteValid", int'(noteValid), 0);

      // relock needs three fresh edges
      tog(8100);
      tog(608);
      wait_cyc(25);
      chk("relock_2edges_noteID", int'(noteID), 0);
      exp_q.push_back(117);
      tog(608);
      wait_cyc(25);
      chk("relock_noteID", int'(noteID), 117);

      // short async reset mid-tone with lineIn low
      if (lineIn) tog(608);
      wait_cyc(300);
      #1 reset = 1'b0;
      #1;
      chk("areset_noteID", int'(noteID), 0);
      chk("areset_noteValid", int'(noteValid), 0);
      chk("areset_noteChanged", int'(noteChanged), 0);
      #1 reset = 1'b1;
      tog(608);
      tog(608);
      wait_cyc(25);
      chk("post_reset_2edges_noteID", int'(noteID), 0);
      exp_q.push_back(117);
      tog(608);
      wait_cyc(25);
      chk("post_reset_lock_noteID", int'(noteID), 117);
      chk("post_reset_lock_noteValid", int'(noteValid), 1);

      wait_cyc(50);
      chk("pending_pulses", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
